instr_encoder_loader: RTL



---
 rtl/instr_encoder_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instruction requests into 32-bit MIPS words and writes them
// into instruction memory at consecutive word addresses, stopping on halt or when memory is full.
module instr_encoder_loader #(
   parameter int ADDR_W     = 8,
   parameter int START_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err_op,
   output logic              err_full
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [2:0]        OP_ADD     = 3'd0;
   localparam logic [2:0]        OP_ADDI    = 3'd1;
   localparam logic [2:0]        OP_LW      = 3'd2;
   localparam logic [2:0]        OP_SW      = 3'd3;
   localparam logic [2:0]        OP_BEQ     = 3'd4;
   localparam logic [2:0]        OP_J       = 3'd5;
   localparam logic [2:0]        OP_HALT    = 3'd6;
   localparam logic [2:0]        OP_ILLEGAL = 3'd7;
   localparam logic [ADDR_W-1:0] START_A    = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LAST_A     = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);

   state_t state;
   logic   we_q;
   logic   pending_halt;
   logic   handshake;

   function automatic logic [31:0] encode(input logic [2:0]  op,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [4:0]  rd,
                                          input logic [15:0] imm,
                                          input logic [25:0] target);
      logic [31:0] word;
      word = 32'd0;
      case (op)
         OP_ADD:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
         OP_ADDI: word = {6'b001000, rs, rt, imm};
         OP_LW:   word = {6'b100011, rs, rt, imm};
         OP_SW:   word = {6'b101011, rs, rt, imm};
         OP_BEQ:  word = {6'b000100, rs, rt, imm};
         OP_J:    word = {6'b000010, target};
         OP_HALT: word = {6'b111111, 26'd0};
         default: word = 32'd0;
      endcase
      return word;
   endfunction

   assign handshake = in_valid && in_ready;

   // A clear landing on the write cycle must suppress the strobe in that same cycle.
   assign imem_we = we_q && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         in_ready     <= 1'b0;
         we_q         <= 1'b0;
         imem_addr    <= START_A;
         imem_wdata   <= 32'd0;
         count        <= '0;
         done         <= 1'b0;
         err_op       <= 1'b0;
         err_full     <= 1'b0;
         pending_halt <= 1'b0;
      end else if (clear) begin
         state        <= IDLE;
         in_ready     <= 1'b1;
         we_q         <= 1'b0;
         imem_addr    <= START_A;
         count        <= '0;
         done         <= 1'b0;
         err_op       <= 1'b0;
         err_full     <= 1'b0;
         pending_halt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (handshake && in_op == OP_ILLEGAL) begin
                  err_op   <= 1'b1;
                  in_ready <= 1'b1;
               end else if (handshake) begin
                  imem_wdata   <= encode(in_op, in_rs, in_rt, in_rd, in_imm, in_target);
                  pending_halt <= (in_op == OP_HALT);
                  we_q         <= 1'b1;
                  in_ready     <= 1'b0;
                  state        <= WRITE;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            // The strobe is high during this state; decide where the next word goes.
            WRITE: begin
               we_q  <= 1'b0;
               count <= count + COUNT_ONE;
               if (pending_halt) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (imem_addr == LAST_A) begin
                  err_full <= 1'b1;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  imem_addr <= imem_addr + 1'b1;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            DONE: begin
               in_ready <= 1'b0;
               done     <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               we_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule
